// File: rtl/mips_mult_pkg.sv
// Shared definitions for the sequential HI/LO multiplier.
//   - ALU-control funct codes recognised by the multiplier (multu / mfhi / mflo)
//   - FSM state encoding (IDLE / RUN / DONE, 2 bits)
//   - default operand and step-counter widths
package mips_mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO result register pair plus the registered mfhi/mflo read port.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high clear of HI, LO and the read register
//   wr_en_i    load {HI,LO} from wr_data_i
//   wr_data_i  2*WIDTH product
//   rd_hi_i    load data_o from HI at this edge
//   rd_lo_i    load data_o from LO at this edge (ignored when rd_hi_i is set)
//   data_o     registered read value for write-back
module hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [2*WIDTH-1:0] wr_data_i,
    input  logic               rd_hi_i,
    input  logic               rd_lo_i,
    output logic [WIDTH-1:0]   data_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            data_q <= '0;
        end else begin
            if (wr_en_i) begin
                {hi_q, lo_q} <= wr_data_i;
            end
            // Reads never coincide with a write (writes only leave RUN,
            // reads are blocked in RUN), so the pre-edge HI/LO is current.
            if (rd_hi_i) begin
                data_q <= hi_q;
            end else if (rd_lo_i) begin
                data_q <= lo_q;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with HI/LO registers.
// One multiplier bit is consumed per cycle; busy stalls the core while running.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset (aborts a running multiply)
//   SIG_MULTIPLIER  funct from ALU control: 25=multu, 16=mfhi, 18=mflo, else no-op
//   dataA           multiplicand (rs)
//   dataB           multiplier (rt)
//   busy            high while in RUN
//   done            one-cycle pulse in DONE, HI/LO just updated
//   dataOut         registered HI/LO read value
// Configuration:
//   MULT_EARLY_TERM_EN  when defined, RUN also ends once the remaining
//                       multiplier bits are all zero (same result, shorter run).
module multu_hilo_unit
    import mips_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       SIG_MULTIPLIER,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    mult_state_e        state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_multu;
    logic               last_step;
    logic [2*WIDTH-1:0] acc_sum;
    logic               hilo_we;
    logic               rd_hi;
    logic               rd_lo;

    assign is_multu = (SIG_MULTIPLIER == F_MULTU);
    assign acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MULT_EARLY_TERM_EN
    // Stop when the bits left after this step are all zero.
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hilo_we  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (is_multu) begin
                    mcand_d  = {{WIDTH{1'b0}}, dataA};
                    mplier_d = dataB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hilo_we = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reads are dropped while a multiply is in flight; dataOut holds.
    assign rd_hi = (SIG_MULTIPLIER == F_MFHI) && (state_q != ST_RUN);
    assign rd_lo = (SIG_MULTIPLIER == F_MFLO) && (state_q != ST_RUN);

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (hilo_we),
        .wr_data_i (acc_sum),
        .rd_hi_i   (rd_hi),
        .rd_lo_i   (rd_lo),
        .data_o    (dataOut)
    );

endmodule
